number_rom_arbiter: RTL and testbench

Shares one 20x20 number-sprite ROM read port (400 pixels × 8 bit, one-cycle registered read) between two pixel requesters, e.g. the score renderer and the countdown renderer. Each requester issues a pixel address and receives the pixel value two cycles after it is granted. Arbitration is round-robin, so neither renderer starves. The block sits between the renderers and the ROM. It also screens out-of-range addresses so the ROM is never read past its 400-entry image.

---
 rtl/number_rom_arbiter.sv | 146 ++++++++++++++
 tb/tb_number_rom_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/number_rom_arbiter.sv
// ---------------------------------------------------------------------------
// number_rom_arbiter
//
// Shares the single read port of the 20x20 number-sprite ROM between two
// pixel requesters (e.g. score renderer and countdown renderer). Requests
// are arbitrated round-robin and answered two cycles after the grant edge.
// Addresses outside the 400-pixel image never reach the ROM; they are
// answered with BLANK and counted in a saturating counter.
//
// Ports:
//   i_clk2                 single clock, rising edge
//   i_rst                  asynchronous active-high reset
//   i_req0/1, i_addr0/1    level requests with their pixel addresses
//   o_gnt0/1               one-cycle registered grant pulses
//   o_rvalid0/1            one-cycle pulse, o_rdata0/1 valid
//   o_rdata0/1             returned pixels, held between pulses
//   o_rom_addr, o_rom_en   ROM read port (registered)
//   i_rom_data             ROM output, valid the cycle after o_rom_en
//   o_oob_cnt              saturating count of out-of-range requests
// ---------------------------------------------------------------------------
module number_rom_arbiter #(
    parameter int                ADDR_W = 10,
    parameter int                DATA_W = 8,
    parameter int                PIXELS = 400,
    parameter logic [DATA_W-1:0] BLANK  = '0
) (
    input  logic              i_clk2,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_rom_en,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [7:0]        o_oob_cnt
);

    // One extra bit so PIXELS == 2**ADDR_W would still compare correctly.
    localparam logic [ADDR_W:0] LP_PIXELS = (ADDR_W+1)'(PIXELS);

    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_en;
    logic [7:0]        r_oob_cnt;
    logic              r_last;      // 1 = requester 1 was served last

    // Tag pipeline: stage 1 is the cycle the ROM is reading, stage 2 the
    // cycle its registered data is on i_rom_data.
    logic              r_s1_valid;
    logic              r_s1_id;
    logic              r_s1_oob;
    logic              r_s2_valid;
    logic              r_s2_id;
    logic              r_s2_oob;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant;
    logic              w_pick1;
    logic [ADDR_W-1:0] w_addr;
    logic              w_oob;

    // A requester still seeing its grant is masked so a held request is
    // not served twice for the same transaction.
    assign w_elig0 = i_req0 & ~r_gnt0;
    assign w_elig1 = i_req1 & ~r_gnt1;
    assign w_grant = w_elig0 | w_elig1;
    // On a tie requester 1 wins only if requester 0 was served last.
    assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);
    assign w_addr  = w_pick1 ? i_addr1 : i_addr0;
    assign w_oob   = ({1'b0, w_addr} >= LP_PIXELS);

    // Issue stage, tag pipeline and return stage all in one register block.
    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_rom_addr <= '0;
            r_rom_en   <= 1'b0;
            r_oob_cnt  <= '0;
            r_last     <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_oob   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= 1'b0;
            r_s2_oob   <= 1'b0;
        end else begin
            r_gnt0     <= w_grant & ~w_pick1;
            r_gnt1     <= w_grant &  w_pick1;
            r_s1_valid <= w_grant;
            r_s1_id    <= w_pick1;
            r_s1_oob   <= w_oob;
            r_rom_en   <= w_grant & ~w_oob;
            if (w_grant) begin
                r_last <= w_pick1;
                // Out-of-range reads leave the ROM address untouched.
                if (!w_oob) begin
                    r_rom_addr <= w_addr;
                end else if (r_oob_cnt != 8'hFF) begin
                    r_oob_cnt <= r_oob_cnt + 8'd1;
                end
            end

            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_oob   <= r_s1_oob;

            r_rvalid0 <= r_s2_valid & ~r_s2_id;
            r_rvalid1 <= r_s2_valid &  r_s2_id;
            if (r_s2_valid && !r_s2_id) begin
                r_rdata0 <= r_s2_oob ? BLANK : i_rom_data;
            end
            if (r_s2_valid && r_s2_id) begin
                r_rdata1 <= r_s2_oob ? BLANK : i_rom_data;
            end
        end
    end

    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_rvalid0  = r_rvalid0;
    assign o_rvalid1  = r_rvalid1;
    assign o_rdata0   = r_rdata0;
    assign o_rdata1   = r_rdata1;
    assign o_rom_addr = r_rom_addr;
    assign o_rom_en   = r_rom_en;
    assign o_oob_cnt  = r_oob_cnt;

endmodule

// File: tb/tb_number_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_number_rom_arbiter
//
// Directed bench for number_rom_arbiter. A small ROM model returns
// mem[a] = a[7:0] one cycle after o_rom_en. Expected values are written
// out by hand per cycle; outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_number_rom_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [9:0] addr0 = '0;
    logic [9:0] addr1 = '0;
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0;
    logic       rvalid1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic [9:0] romAddr;
    logic       romEn;
    logic [7:0] romData = '0;
    logic [7:0] oobCnt;

    int checkCount = 0;
    int failCount  = 0;

    number_rom_arbiter dut (
        .i_clk2    (clk),
        .i_rst     (rst),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_addr0   (addr0),
        .i_addr1   (addr1),
        .o_gnt0    (gnt0),
        .o_gnt1    (gnt1),
        .o_rvalid0 (rvalid0),
        .o_rvalid1 (rvalid1),
        .o_rdata0  (rdata0),
        .o_rdata1  (rdata1),
        .o_rom_addr(romAddr),
        .o_rom_en  (romEn),
        .i_rom_data(romData),
        .o_oob_cnt (oobCnt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // ROM model: one-cycle registered read, holds output when not enabled
    always @(posedge clk) begin
        if (romEn) romData <= romAddr[7:0];
    end

    // Counts one comparison and reports it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Both return channels must never pulse together
    always @(negedge clk) begin
        if (!rst) checkOutput("rvalidBoth", {31'd0, rvalid0 & rvalid1}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic [9:0] a0,
                                 input logic r1, input logic [9:0] a1);
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int grants;

    initial begin
        // ---- reset state ----
        resetDut();
        checkOutput("rstGnt",    {30'd0, gnt0, gnt1}, 32'd0);
        checkOutput("rstRvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
        checkOutput("rstRomEn",  {31'd0, romEn}, 32'd0);
        checkOutput("rstRomAddr", {22'd0, romAddr}, 32'd0);
        checkOutput("rstOob",    {24'd0, oobCnt}, 32'd0);
        checkOutput("rstRdata",  {16'd0, rdata0, rdata1}, 32'd0);

        // ---- single read, address 0 ----
        applyStimulus(1'b1, 10'd0, 1'b0, 10'd0);
        tick();
        checkOutput("t1Gnt0",   {31'd0, gnt0}, 32'd1);
        checkOutput("t1RomEn",  {31'd0, romEn}, 32'd1);
        checkOutput("t1RomAddr", {22'd0, romAddr}, 32'd0);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        tick();
        checkOutput("t1RvEarly", {31'd0, rvalid0}, 32'd0);
        tick();
        checkOutput("t1Rvalid0", {31'd0, rvalid0}, 32'd1);
        checkOutput("t1Rdata0",  {24'd0, rdata0}, 32'h00);
        tick();
        checkOutput("t1RvEnd", {31'd0, rvalid0}, 32'd0);

        // ---- tie and fairness ----
        resetDut();
        applyStimulus(1'b1, 10'd5, 1'b1, 10'd7);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput("tieGnt0", {31'd0, gnt0}, {31'd0, k[0]});
            checkOutput("tieGnt1", {31'd0, gnt1}, {31'd0, ~k[0]});
            if (k >= 3) begin
                checkOutput("tieRv0", {31'd0, rvalid0}, {31'd0, k[0]});
                checkOutput("tieRv1", {31'd0, rvalid1}, {31'd0, ~k[0]});
            end
        end
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        tick();
        tick();
        checkOutput("tieRdata0", {24'd0, rdata0}, 32'h05);
        checkOutput("tieRdata1", {24'd0, rdata1}, 32'h07);

        // ---- address boundaries ----
        resetDut();
        applyStimulus(1'b0, 10'd0, 1'b1, 10'd399);
        tick();
        checkOutput("b399Gnt1",  {31'd0, gnt1}, 32'd1);
        checkOutput("b399RomEn", {31'd0, romEn}, 32'd1);
        checkOutput("b399Addr",  {22'd0, romAddr}, 32'd399);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        tick();
        tick();
        checkOutput("b399Rv1",   {31'd0, rvalid1}, 32'd1);
        checkOutput("b399Data",  {24'd0, rdata1}, 32'h8F);
        applyStimulus(1'b0, 10'd0, 1'b1, 10'd400);
        tick();
        checkOutput("b400Gnt1",  {31'd0, gnt1}, 32'd1);
        checkOutput("b400RomEn", {31'd0, romEn}, 32'd0);
        checkOutput("b400Addr",  {22'd0, romAddr}, 32'd399);
        checkOutput("b400Oob",   {24'd0, oobCnt}, 32'd1);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        tick();
        tick();
        checkOutput("b400Rv1",   {31'd0, rvalid1}, 32'd1);
        checkOutput("b400Data",  {24'd0, rdata1}, 32'h00);
        // 260 further OOB grants: holding the request grants every other cycle
        applyStimulus(1'b0, 10'd0, 1'b1, 10'd1023);
        for (int k = 0; k < 520; k++) tick();
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        tick();
        tick();
        checkOutput("oobSat",    {24'd0, oobCnt}, 32'd255);
        checkOutput("oobAddr",   {22'd0, romAddr}, 32'd399);

        // ---- single continuous requester ----
        resetDut();
        grants = 0;
        applyStimulus(1'b1, 10'd3, 1'b0, 10'd0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 10) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
            if (gnt0) grants++;
            checkOutput("contGnt0", {31'd0, gnt0}, {31'd0, (k <= 10) && k[0]});
            checkOutput("contRv0",  {31'd0, rvalid0}, {31'd0, (k >= 3) && k[0]});
        end
        checkOutput("contGrants", grants, 32'd5);
        checkOutput("contRdata0", {24'd0, rdata0}, 32'h03);

        // ---- reset mid-flight ----
        resetDut();
        applyStimulus(1'b1, 10'd9, 1'b0, 10'd0);
        tick();
        checkOutput("rmGnt0", {31'd0, gnt0}, 32'd1);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        rst = 1'b1;
        #1;
        checkOutput("rmGntNow",  {30'd0, gnt0, gnt1}, 32'd0);
        checkOutput("rmRomEn",   {31'd0, romEn}, 32'd0);
        checkOutput("rmRomAddr", {22'd0, romAddr}, 32'd0);
        checkOutput("rmOob",     {24'd0, oobCnt}, 32'd0);
        checkOutput("rmRdata",   {16'd0, rdata0, rdata1}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 10'd2, 1'b1, 10'd4);
        checkOutput("rmRvA", {31'd0, rvalid0}, 32'd0);
        tick();
        checkOutput("rmTieGnt0", {31'd0, gnt0}, 32'd1);
        checkOutput("rmTieGnt1", {31'd0, gnt1}, 32'd0);
        checkOutput("rmRvB", {31'd0, rvalid0}, 32'd0);
        tick();
        checkOutput("rmGnt1", {31'd0, gnt1}, 32'd1);
        checkOutput("rmRvC", {31'd0, rvalid0}, 32'd0);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
        tick();
        checkOutput("rmRvNew",   {31'd0, rvalid0}, 32'd1);
        checkOutput("rmRdata0",  {24'd0, rdata0}, 32'h02);
        tick();
        checkOutput("rmRv1",     {31'd0, rvalid1}, 32'd1);
        checkOutput("rmRdata1",  {24'd0, rdata1}, 32'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
